// File: rtl/permute_stage.sv
// permute_stage: sequential pi-permutation over a 5x5xNUM_PAGE bit state.
// A start request snapshots the whole state, then one output cell is written
// per clock as out[i][j][k] = in[(i+3j) mod 5][i][k], walking i fastest,
// then j, then k. A one-cycle done pulse marks a complete output buffer.
//
// Handshake: start is a request that is only looked at in IDLE (it is ignored,
// not queued, in RUN and DONE). busy is high from the cycle after acceptance
// through the cycle of the last cell write. done is high for exactly one
// cycle after the last write. From then on data_out is valid and holds
// until the next accepted start begins overwriting it.
module permute_stage #(
  parameter int NUM_ROW    = 5,
  parameter int NUM_COLUMN = 5,
  parameter int NUM_PAGE   = 64,
  parameter int NUM_CELLS  = NUM_ROW * NUM_COLUMN * NUM_PAGE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CELLS-1:0] data_out
);

  // Counter and address widths.
  localparam int IW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int JW = (NUM_COLUMN > 1) ? $clog2(NUM_COLUMN) : 1;
  localparam int KW = (NUM_PAGE > 1) ? $clog2(NUM_PAGE) : 1;
  localparam int AW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  // i + 3j reaches 4 + 12 = 16 for a 5x5 plane, so two guard bits above i.
  localparam int SW = IW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [IW-1:0]        i;
  logic [JW-1:0]        j;
  logic [KW-1:0]        k;
  logic [NUM_CELLS-1:0] snap;

  logic          i_wrap;
  logic          j_wrap;
  logic          k_wrap;
  logic [SW-1:0] rot_sum;
  logic [IW-1:0] rot;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] src_addr;

  // Counter overflow flags: i wraps at NUM_ROW, j at NUM_COLUMN, k at NUM_PAGE.
  assign i_wrap = (i == IW'(NUM_ROW - 1));
  assign j_wrap = (j == JW'(NUM_COLUMN - 1));
  assign k_wrap = (k == KW'(NUM_PAGE - 1));

  // Source row (i + 3j) mod 5, summed wide enough that nothing overflows.
  assign rot_sum = SW'(i) + SW'(j) + SW'(j) + SW'(j);
  assign rot     = IW'(rot_sum % SW'(NUM_ROW));

  // Destination cell (i, j, k) and source cell (rot, i, k) in flat indexing.
  assign dst_addr = AW'(k) * AW'(NUM_ROW * NUM_COLUMN) + AW'(j) * AW'(NUM_ROW) + AW'(i);
  assign src_addr = AW'(k) * AW'(NUM_ROW * NUM_COLUMN) + AW'(i) * AW'(NUM_ROW) + AW'(rot);

  // Control FSM, cell counters, snapshot and output buffer in one registered block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      snap     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= data_in;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          data_out[dst_addr] <= snap[src_addr];
          if (i_wrap) begin
            i <= '0;
            if (j_wrap) begin
              j <= '0;
              if (k_wrap) begin
                k     <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_permute_stage.sv
// tb_permute_stage: directed bench for permute_stage with a 3-D array model
// of the pi permutation and a queue of expected output buffers.
module tb_permute_stage;

  localparam int N       = 1600;
  localparam int LAT     = 1601;
  localparam int LIMIT   = 5000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] cur_exp = '0;

  // Clock
  always #5 clk = ~clk;

  permute_stage dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  // Model: a[i][j][k] = v[k*25 + j*5 + i]; out[i][j][k] = a[(i+3j)%5][i][k].
  function automatic logic [N-1:0] model(input logic [N-1:0] v);
    logic a [5][5][64];
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 5; j++)
        for (int i = 0; i < 5; i++)
          a[i][j][k] = v[k*25 + j*5 + i];
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 5; j++)
        for (int i = 0; i < 5; i++)
          r[k*25 + j*5 + i] = a[(i + 3*j) % 5][i][k];
    return r;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int w = 0; w < N/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    logic [N-1:0] diff;
    int first;
    int cnt;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      diff  = act ^ exp;
      first = -1;
      cnt   = 0;
      for (int b = 0; b < N; b++) begin
        if (diff[b] !== 1'b0) begin
          cnt++;
          if (first < 0) first = b;
        end
      end
      if (first >= 0)
        $display("FAIL %s: %0d bits differ, first bit %0d got %b expected %b",
                 name, cnt, first, act[first], exp[first]);
      else
        $display("FAIL %s: vectors differ", name);
    end
  endtask

  // Scoreboard: pop on every done, and check the held buffer on idle cycles.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      cur_exp = '0;
    end else if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_int("unexpected_done", 1, 0);
      end else begin
        cur_exp = exp_q.pop_front();
        check_vec("done_data", data_out, cur_exp);
      end
    end else if (!busy) begin
      check_vec("hold_data", data_out, cur_exp);
    end
  end

  // Drive start for one accepted run; the caller is at posedge+1.
  task automatic launch(input logic [N-1:0] v);
    data_in = v;
    start   = 1'b1;
    exp_q.push_back(model(v));
  endtask

  task automatic run_vec(input string name, input logic [N-1:0] v);
    int n;
    launch(v);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check_int({name, "_busy_after_start"}, int'(busy), 1);
    while (!done && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_int({name, "_latency"}, n, LAT);
    check_int({name, "_busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    check_int({name, "_done_one_cycle"}, int'(done), 0);
  endtask

  // Directed stimulus
  initial begin
    logic [N-1:0] e_in;
    logic [N-1:0] e_out;
    logic [N-1:0] ones;
    logic [N-1:0] v;
    int n;
    int dc0;
    int low_cnt;
    int d1;
    int d2;

    ones = '1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_vec("rst_data", data_out, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single bit at cell (1,0,0) moves to cell (0,2,0)
    e_in = '0; e_in[1] = 1'b1;
    e_out = '0; e_out[10] = 1'b1;
    check_vec("model_bit1", model(e_in), e_out);
    run_vec("bit1", e_in);
    check_vec("lit_bit1", data_out, e_out);

    // Cell (2,3,5) moves to cell (3,3,5)
    e_in = '0; e_in[142] = 1'b1;
    e_out = '0; e_out[143] = 1'b1;
    check_vec("model_bit142", model(e_in), e_out);
    run_vec("bit142", e_in);
    check_vec("lit_bit142", data_out, e_out);

    // Fixed points i=0, j=0 in pages 0 and 63
    e_in = '0; e_in[0] = 1'b1; e_in[1575] = 1'b1;
    check_vec("model_fixed", model(e_in), e_in);
    run_vec("fixed", e_in);
    check_vec("lit_fixed", data_out, e_in);

    // All ones
    check_vec("model_ones", model(ones), ones);
    run_vec("ones", ones);
    check_vec("lit_ones", data_out, ones);

    // Random vector with data_in churn and an ignored start mid-run
    v = rand_vec();
    dc0 = done_cnt;
    launch(v);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
      if (n == 10) data_in = ~v;
      if (n == 500) begin
        data_in = rand_vec();
        start   = 1'b1;
      end
      if (n == 501) start = 1'b0;
    end
    check_int("midrun_latency", n, LAT);
    check_vec("midrun_data", data_out, model(v));
    repeat (30) @(posedge clk);
    #1;
    check_int("midrun_one_done", done_cnt - dc0, 1);

    // Asynchronous reset at cycle 800 of a run
    launch(ones);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (799) @(posedge clk);
    #3;
    check_int("pre_rst_partial", int'(data_out != '0), 1);
    rst = 1'b1;
    #1;
    check_int("async_rst_busy", int'(busy), 0);
    check_int("async_rst_done", int'(done), 0);
    check_vec("async_rst_data", data_out, '0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    v = rand_vec();
    run_vec("after_rst", v);
    check_vec("after_rst_data", data_out, model(v));

    // start held high for 4000 cycles: back-to-back runs
    v = rand_vec();
    data_in = v;
    exp_q.push_back(model(v));
    exp_q.push_back(model(v));
    exp_q.push_back(model(v));
    start   = 1'b1;
    low_cnt = 0;
    d1 = -1;
    d2 = -1;
    dc0 = done_cnt;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (!busy) low_cnt++;
      if (c == 1602) check_int("held_busy_idle_gap", int'(busy), 0);
      if (c == 1603) check_int("held_busy_restart", int'(busy), 1);
    end
    start = 1'b0;
    check_int("held_done1", d1, 1601);
    check_int("held_done2", d2, 3203);
    check_int("held_busy_low_cycles", low_cnt, 4);
    n = 0;
    while (!done && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_int("held_third_done", n, 805);
    repeat (5) @(posedge clk);
    #1;
    check_int("held_done_count", done_cnt - dc0, 3);
    check_int("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
